// File: rtl/dct8_pipe.sv
// dct8_pipe: 8-point forward DCT, 3-stage valid/ready pipeline
// (butterfly, multiply-accumulate, shift/saturate).
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_data    8 x IN_W signed samples, x[0] in MSBs
//   in_valid   in_data valid
//   in_ready   pipeline can accept this cycle
//   pass_sel   0 = row pass (ROW_SHIFT), 1 = column pass (COL_SHIFT)
//   out_data   8 x OUT_W signed coefficients, Y[0] in MSBs
//   out_valid  out_data valid
//   out_ready  downstream accepts out_data
//   out_row    row index (0..7) of presented vector in its 8x8 block
//   out_last   presented vector is row 7
//
// Build option: DCT8_PIPE_ROUND_EN selects round-half-up before the
// shift; left undefined the shift truncates toward minus infinity.

module dct8_pipe #(
  parameter int IN_W      = 9,
  parameter int OUT_W     = 10,
  parameter int ROW_SHIFT = 5,
  parameter int COL_SHIFT = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [8*IN_W-1:0]  in_data,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               pass_sel,
  output logic [8*OUT_W-1:0] out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2:0]         out_row,
  output logic               out_last
);

  localparam int BF_W  = IN_W + 1;
  localparam int ACC_W = IN_W + 10;
  localparam int EXT_W = ACC_W + 1;

  // Left half of the cosine matrix; the right half mirrors it
  // (even rows symmetric, odd rows antisymmetric), which is what
  // lets the butterfly halve the multiplier count.
  localparam logic signed [7:0] C [8][4] = '{
    '{ 8'sd45,  8'sd45,  8'sd45,  8'sd45},
    '{ 8'sd63,  8'sd53,  8'sd36,  8'sd12},
    '{ 8'sd59,  8'sd24, -8'sd24, -8'sd59},
    '{ 8'sd53, -8'sd12, -8'sd63, -8'sd36},
    '{ 8'sd45, -8'sd45, -8'sd45,  8'sd45},
    '{ 8'sd36, -8'sd63,  8'sd12,  8'sd53},
    '{ 8'sd24, -8'sd59,  8'sd59, -8'sd24},
    '{ 8'sd12, -8'sd36,  8'sd53, -8'sd63}
  };

`ifdef DCT8_PIPE_ROUND_EN
  localparam logic signed [EXT_W-1:0] RND_R =
    EXT_W'(1) << (ROW_SHIFT - 1);
  localparam logic signed [EXT_W-1:0] RND_C =
    EXT_W'(1) << (COL_SHIFT - 1);
`else
  localparam logic signed [EXT_W-1:0] RND_R = '0;
  localparam logic signed [EXT_W-1:0] RND_C = '0;
`endif

  localparam logic signed [EXT_W-1:0] O_MAX =
    EXT_W'(2**(OUT_W-1) - 1);
  localparam logic signed [EXT_W-1:0] O_MIN =
    EXT_W'(-(2**(OUT_W-1)));

  typedef struct packed {
    logic                 vld;
    logic                 psel;
    logic [2:0]           row;
    logic [3:0][BF_W-1:0] s;
    logic [3:0][BF_W-1:0] d;
  } bf_t;

  typedef struct packed {
    logic                  vld;
    logic                  psel;
    logic [2:0]            row;
    logic [7:0][ACC_W-1:0] y;
  } mac_t;

  logic                    w_adv;
  logic signed [IN_W-1:0]  w_x [8];
  bf_t                     w_bf;
  bf_t                     r_bf;
  mac_t                    w_mac;
  mac_t                    r_mac;
  logic signed [ACC_W-1:0] w_op;
  logic signed [EXT_W-1:0] w_t;
  logic signed [EXT_W-1:0] w_sh;
  logic [7:0][OUT_W-1:0]   w_y;
  logic [8*OUT_W-1:0]      r_od;
  logic                    r_ov;
  logic [2:0]              r_orow;
  logic [2:0]              r_in_row;

  // One global enable: the whole pipe freezes while the
  // output slot is full and not being taken.
  assign w_adv    = !r_ov || out_ready;
  assign in_ready = w_adv;

  always_comb begin
    for (int n = 0; n < 8; n++) begin
      w_x[n] = in_data[(7-n)*IN_W +: IN_W];
    end
  end

  // Stage 1: butterfly sums/differences
  always_comb begin
    w_bf      = '0;
    w_bf.vld  = in_valid;
    w_bf.psel = pass_sel;
    w_bf.row  = r_in_row;
    for (int n = 0; n < 4; n++) begin
      w_bf.s[n] = BF_W'(w_x[n]) + BF_W'(w_x[7-n]);
      w_bf.d[n] = BF_W'(w_x[n]) - BF_W'(w_x[7-n]);
    end
  end

  // Stage 2: 4-tap MAC per coefficient, full precision
  always_comb begin
    w_mac      = '0;
    w_op       = '0;
    w_mac.vld  = r_bf.vld;
    w_mac.psel = r_bf.psel;
    w_mac.row  = r_bf.row;
    for (int k = 0; k < 8; k++) begin
      for (int n = 0; n < 4; n++) begin
        if (k % 2 == 0) begin
          w_op = ACC_W'($signed(r_bf.s[n]));
        end else begin
          w_op = ACC_W'($signed(r_bf.d[n]));
        end
        w_mac.y[k] = w_mac.y[k]
          + ACC_W'(w_op * ACC_W'(C[k][n]));
      end
    end
  end

  // Stage 3: shift then clamp; one guard bit keeps the
  // rounding add from wrapping at the top of the range.
  always_comb begin
    w_y  = '0;
    w_t  = '0;
    w_sh = '0;
    for (int k = 0; k < 8; k++) begin
      w_t = EXT_W'($signed(r_mac.y[k]));
      if (r_mac.psel) begin
        w_sh = (w_t + RND_C) >>> COL_SHIFT;
      end else begin
        w_sh = (w_t + RND_R) >>> ROW_SHIFT;
      end
      if (w_sh > O_MAX) begin
        w_y[7-k] = O_MAX[OUT_W-1:0];
      end else if (w_sh < O_MIN) begin
        w_y[7-k] = O_MIN[OUT_W-1:0];
      end else begin
        w_y[7-k] = w_sh[OUT_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bf     <= '0;
      r_mac    <= '0;
      r_ov     <= 1'b0;
      r_od     <= '0;
      r_orow   <= '0;
      r_in_row <= '0;
    end else if (w_adv) begin
      r_bf  <= w_bf;
      r_mac <= w_mac;
      r_ov  <= r_mac.vld;
      if (r_mac.vld) begin
        r_od   <= w_y;
        r_orow <= r_mac.row;
      end
      if (in_valid) begin
        r_in_row <= r_in_row + 3'd1;
      end
    end
  end

  assign out_data  = r_od;
  assign out_valid = r_ov;
  assign out_row   = r_orow;
  assign out_last  = r_ov && (r_orow == 3'd7);

endmodule

// File: tb/tb_dct8_pipe.sv
// tb_dct8_pipe: self-checking bench for dct8_pipe.
// Directed table, stall/reset sequences, random traffic vs model.

module tb_dct8_pipe;

  localparam int IN_W      = 9;
  localparam int OUT_W     = 10;
  localparam int ROW_SHIFT = 5;
  localparam int COL_SHIFT = 7;
`ifdef DCT8_PIPE_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic [8*IN_W-1:0]  in_data;
  logic               in_valid;
  logic               in_ready;
  logic               pass_sel;
  logic [8*OUT_W-1:0] out_data;
  logic               out_valid;
  logic               out_ready;
  logic [2:0]         out_row;
  logic               out_last;

  always #5 clk = ~clk;

  dct8_pipe #(
    .IN_W(IN_W), .OUT_W(OUT_W),
    .ROW_SHIFT(ROW_SHIFT), .COL_SHIFT(COL_SHIFT)
  ) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .pass_sel(pass_sel),
    .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_row(out_row),
    .out_last(out_last)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk_i(input string nm, input longint act,
                       input longint exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_v(input string nm,
                       input logic [8*OUT_W-1:0] act,
                       input logic [8*OUT_W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // DCT basis straight from the cosine definition
  function automatic int coefw(input int k, input int n);
    real c;
    if (k == 0) return 45;
    c = 64.0 * $cos(real'((2*n+1)*k) * 3.141592653589793 / 16.0);
    if (c >= 0.0) return int'($floor(c + 0.5));
    return -int'($floor(-c + 0.5));
  endfunction

  function automatic logic [8*OUT_W-1:0] model(
      input logic [8*IN_W-1:0] d, input logic p);
    logic [8*OUT_W-1:0] r;
    longint acc, y, xv, lim;
    int sh;
    r = '0;
    sh = p ? COL_SHIFT : ROW_SHIFT;
    lim = longint'(1) << (OUT_W - 1);
    for (int k = 0; k < 8; k++) begin
      acc = 0;
      for (int n = 0; n < 8; n++) begin
        xv = $signed(d[(7-n)*IN_W +: IN_W]);
        acc += xv * coefw(k, n);
      end
      if (RND) acc += longint'(1) << (sh - 1);
      y = acc >>> sh;
      if (y > lim - 1) y = lim - 1;
      if (y < -lim) y = -lim;
      r[(7-k)*OUT_W +: OUT_W] = y[OUT_W-1:0];
    end
    return r;
  endfunction

  function automatic int coef_out(input int k);
    logic [OUT_W-1:0] v;
    v = out_data[(7-k)*OUT_W +: OUT_W];
    return $signed(v);
  endfunction

  function automatic logic [8*IN_W-1:0] mkvec(input int a0,
                                               input int ar);
    logic [8*IN_W-1:0] v;
    v = '0;
    v[7*IN_W +: IN_W] = IN_W'(a0);
    for (int n = 1; n < 8; n++) v[(7-n)*IN_W +: IN_W] = IN_W'(ar);
    return v;
  endfunction

  // Scoreboard: expected vectors queued on input transfer
  typedef struct {
    logic [8*OUT_W-1:0] d;
    logic [2:0]         row;
  } exp_t;

  exp_t               q[$];
  int                 mrow = 0;
  logic               hold_v = 1'b0;
  logic [8*OUT_W-1:0] hold_d;
  int                 log_row[$];
  int                 log_last[$];

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      q.delete();
      mrow   = 0;
      hold_v = 1'b0;
    end else begin
      if (out_valid && hold_v) chk_v("hold", out_data, hold_d);
      hold_v = out_valid && !out_ready;
      hold_d = out_data;
      if (out_valid)
        chk_i("last_flag", out_last, (out_row == 3'd7) ? 1 : 0);
      if (out_valid && out_ready) begin
        log_row.push_back(out_row);
        log_last.push_back(out_last);
        if (q.size() == 0) begin
          chk_i("unexpected_out", 1, 0);
        end else begin
          e = q.pop_front();
          chk_v("data", out_data, e.d);
          chk_i("row", out_row, e.row);
        end
      end
      if (in_valid && in_ready) begin
        q.push_back('{model(in_data, pass_sel), 3'(mrow)});
        mrow = (mrow + 1) % 8;
      end
    end
  end

  typedef struct {
    int x0;
    int xr;
    bit p;
    int k;
    int e;
  } tv_t;

  tv_t tv[12];

  task automatic send_one(input logic [8*IN_W-1:0] d, input logic p,
                          output int lat);
    in_data   = d;
    pass_sel  = p;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic do_reset();
    #1 rst = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1);
  end

  initial begin
    int lat, sent, val;
    bit acc;
    logic [8*IN_W-1:0] sv[10];

    rst = 1'b1; in_valid = 1'b0; in_data = '0;
    pass_sel = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_i("rst_valid", out_valid, 0);
    chk_v("rst_data", out_data, '0);
    chk_i("rst_row", out_row, 0);
    chk_i("rst_last", out_last, 0);
    rst = 1'b0;
    #1 chk_i("ready_after_rst", in_ready, 1);

    tv[0]  = '{1, 1, 0, 0, 11};
    tv[1]  = '{1, 1, 0, 1, 0};
    tv[2]  = '{1, 1, 1, 0, RND ? 3 : 2};
    tv[3]  = '{1, 1, 1, 5, 0};
    tv[4]  = '{100, 0, 0, 1, RND ? 197 : 196};
    tv[5]  = '{100, 0, 0, 2, 184};
    tv[6]  = '{100, 0, 0, 4, RND ? 141 : 140};
    tv[7]  = '{100, 0, 0, 0, RND ? 141 : 140};
    tv[8]  = '{255, 255, 0, 0, 511};
    tv[9]  = '{-256, -256, 0, 0, -512};
    tv[10] = '{-100, 0, 0, 2, RND ? -184 : -185};
    tv[11] = '{100, 0, 0, 7, RND ? 38 : 37};

    for (int i = 0; i < 12; i++) begin
      send_one(mkvec(tv[i].x0, tv[i].xr), tv[i].p, lat);
      chk_i($sformatf("tv%0d_lat", i), lat, 3);
      chk_i($sformatf("tv%0d_Y%0d", i, tv[i].k),
            coef_out(tv[i].k), tv[i].e);
      @(posedge clk);
      #1;
    end

    // Ten back-to-back vectors with a 5-cycle output stall
    do_reset();
    log_row.delete();
    log_last.delete();
    for (int i = 0; i < 10; i++) begin
      for (int n = 0; n < 8; n++)
        sv[i][n*IN_W +: IN_W] = IN_W'($urandom_range(0, 511));
    end
    sent = 0;
    for (int c = 0; c < 60 && sent < 10; c++) begin
      out_ready = !(c >= 3 && c < 8);
      in_valid  = 1'b1;
      in_data   = sv[sent];
      pass_sel  = sent[0];
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (acc) sent++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int t = 0; t < 20 && q.size() > 0; t++) begin
      @(posedge clk);
      #1;
    end
    chk_i("stall_sent", sent, 10);
    chk_i("stall_count", log_row.size(), 10);
    chk_i("stall_row7", log_row.size() > 7 ? log_row[7] : -1, 7);
    chk_i("stall_last8", log_last.size() > 7 ? log_last[7] : -1, 1);
    chk_i("stall_row9", log_row.size() > 8 ? log_row[8] : -1, 0);
    chk_i("stall_last9", log_last.size() > 8 ? log_last[8] : -1, 0);

    // Reset with two vectors in flight
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = mkvec(7, 3);
    pass_sel  = 1'b0;
    @(posedge clk);
    #1 in_data = mkvec(-5, 9);
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk_i("rst2_filled", out_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk_i("rst2_valid", out_valid, 0);
    chk_v("rst2_data", out_data, '0);
    chk_i("rst2_row", out_row, 0);
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    for (int t = 0; t < 5; t++) begin
      @(posedge clk);
      #1 chk_i("rst2_flushed", out_valid, 0);
    end
    send_one(mkvec(2, -1), 1'b1, lat);
    chk_i("rst2_lat", lat, 3);
    chk_i("rst2_first_row", out_row, 0);
    @(posedge clk);
    #1;

    // Random traffic with random back-pressure
    for (int c = 0; c < 400; c++) begin
      in_valid = ($urandom % 10) < 7;
      for (int n = 0; n < 8; n++) begin
        if ($urandom % 8 == 0) val = ($urandom % 2) ? 255 : -256;
        else val = int'($urandom_range(0, 511)) - 256;
        in_data[n*IN_W +: IN_W] = IN_W'(val);
      end
      pass_sel  = $urandom % 2;
      out_ready = ($urandom % 10) < 7;
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int t = 0; t < 20 && q.size() > 0; t++) begin
      @(posedge clk);
      #1;
    end
    chk_i("drain", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
